// File: rtl/alu_exec_if.sv
// Issue and write-back handshake bundle between the instruction source, alu_exec_ctrl
// and the register-file write port.
interface alu_exec_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [6:0]   in_op;
    logic [3:0]   in_cond;
    logic         in_set_flags;
    logic [3:0]   in_rd;
    logic [W-1:0] in_rn;
    logic [W-1:0] in_op2;

    logic         out_valid;
    logic         out_ready;
    logic         out_we;
    logic [3:0]   out_rd;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_op, in_cond, in_set_flags, in_rd, in_rn, in_op2, out_ready,
        input  in_ready, out_valid, out_we, out_rd, out_data
    );

    modport slave (
        input  in_valid, in_op, in_cond, in_set_flags, in_rd, in_rn, in_op2, out_ready,
        output in_ready, out_valid, out_we, out_rd, out_data
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Issue/retire controller for the combinational ALU: condition check against NZCV,
// single-entry write-back register, flag register and retired-op counter.
module alu_exec_ctrl #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_exec_if.slave        bus,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [6:0]       alu_sel,
    input  logic [W-1:0]     alu_data,
    input  logic [3:0]       alu_flag,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             op_err
);
    localparam logic [6:0] OP_CMP = 7'b0010000;

    function automatic logic is_onehot(input logic [6:0] op);
        return (op != 7'd0) && ((op & (op - 7'd1)) == 7'd0);
    endfunction

    // flags layout is {Z,N,C,V}
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic z, n, c, v, r;
        {z, n, c, v} = f;
        case (cond)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = c;
            4'b0011: r = !c;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = c && !z;
            4'b1001: r = !c || z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z && (n == v);
            4'b1101: r = z || (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic         vld_p1;
    logic         we_p1;
    logic [3:0]   rd_p1;
    logic [W-1:0] data_p1;

    logic         accept;
    logic         op_ok;
    logic         pass;
    logic         is_cmp;
    logic         is_arith;
    logic         flag_upd;
    logic [3:0]   flags_nxt;

    assign alu_a   = bus.in_op2;
    assign alu_b   = bus.in_rn;
    assign alu_sel = bus.in_op;

    assign bus.in_ready = !vld_p1 || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign op_ok    = is_onehot(bus.in_op);
    assign pass     = op_ok && cond_pass(bus.in_cond, flags);
    assign is_cmp   = (bus.in_op == OP_CMP);
    assign is_arith = |bus.in_op[6:4];
    assign flag_upd = accept && pass && (bus.in_set_flags || is_cmp);

    // Logical ops and MOV leave C and V untouched
    assign flags_nxt = is_arith ? alu_flag : {alu_flag[3:2], flags[1:0]};

    // Stage p1: write-back entry, architectural flags and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1     <= 1'b0;
            we_p1      <= 1'b0;
            rd_p1      <= 4'd0;
            data_p1    <= '0;
            flags      <= 4'd0;
            retire_cnt <= '0;
            op_err     <= 1'b0;
        end else begin
            if (accept) begin
                vld_p1  <= 1'b1;
                we_p1   <= pass && !is_cmp;
                rd_p1   <= bus.in_rd;
                data_p1 <= alu_data;
                if (pass)
                    retire_cnt <= retire_cnt + 1'b1;
                if (!op_ok)
                    op_err <= 1'b1;
            end else if (bus.out_ready) begin
                vld_p1 <= 1'b0;
            end
            if (flag_upd)
                flags <= flags_nxt;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_we    = we_p1;
    assign bus.out_rd    = rd_p1;
    assign bus.out_data  = data_p1;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_alu_exec_ctrl;
    localparam int W     = 32;
    localparam int CNT_W = 8;

    localparam logic [6:0] ADD = 7'b1000000;
    localparam logic [6:0] SUB = 7'b0100000;
    localparam logic [6:0] CMP = 7'b0010000;
    localparam logic [6:0] AND = 7'b0001000;
    localparam logic [6:0] ORR = 7'b0000100;
    localparam logic [6:0] EOR = 7'b0000010;
    localparam logic [6:0] MOV = 7'b0000001;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [W-1:0]     alu_a, alu_b, alu_data;
    logic [6:0]       alu_sel;
    logic [3:0]       alu_flag;
    logic [3:0]       flags;
    logic [CNT_W-1:0] retire_cnt;
    logic             op_err;

    int n_checks = 0;
    int n_err    = 0;

    alu_exec_if #(.W(W)) bus ();

    alu_exec_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_data   (alu_data),
        .alu_flag   (alu_flag),
        .flags      (flags),
        .retire_cnt (retire_cnt),
        .op_err     (op_err)
    );

    always #5 clk = ~clk;

    // Combinational ALU: SUB/CMP give b - a, MOV passes a; result is {Z,N,C,V, data}
    function automatic logic [W+3:0] alu_fn(input logic [6:0] sel, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        r = '0; c = 1'b0; v = 1'b0; s = '0;
        case (sel)
            ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            SUB, CMP: begin
                s = {1'b0, b} + {1'b0, ~a} + 1'b1;
                r = s[W-1:0]; c = s[W];
                v = (b[W-1] != a[W-1]) && (r[W-1] != b[W-1]);
            end
            AND:     r = a & b;
            ORR:     r = a | b;
            EOR:     r = a ^ b;
            MOV:     r = a;
            default: r = '0;
        endcase
        return {(r == '0), r[W-1], c, v, r};
    endfunction

    assign {alu_flag, alu_data} = alu_fn(alu_sel, alu_a, alu_b);

    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic z, n, c, v, base;
        {z, n, c, v} = f;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return cond[0] ? !base : base;
    endfunction

    // Behavioural model, computed directly from the issued operands
    logic             m_vld = 1'b0, m_we = 1'b0, m_err = 1'b0;
    logic [3:0]       m_rd = 4'd0, m_flags = 4'd0;
    logic [W-1:0]     m_data = '0;
    logic [CNT_W-1:0] m_cnt = '0;

    logic         mdl_ok, mdl_pass, mdl_cmp, mdl_acc;
    logic [W+3:0] mdl_res;

    assign mdl_ok   = ($countones(bus.in_op) == 1);
    assign mdl_pass = mdl_ok && cond_ok(bus.in_cond, m_flags);
    assign mdl_cmp  = (bus.in_op == CMP);
    assign mdl_res  = alu_fn(bus.in_op, bus.in_op2, bus.in_rn);
    assign mdl_acc  = bus.in_valid && (!m_vld || bus.out_ready);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_vld <= 1'b0; m_we <= 1'b0; m_rd <= 4'd0; m_data <= '0;
            m_flags <= 4'd0; m_cnt <= '0; m_err <= 1'b0;
        end else if (mdl_acc) begin
            m_vld  <= 1'b1;
            m_rd   <= bus.in_rd;
            m_data <= mdl_res[W-1:0];
            m_we   <= mdl_pass && !mdl_cmp;
            if (mdl_pass) m_cnt <= m_cnt + 1'b1;
            if (!mdl_ok) m_err <= 1'b1;
            if (mdl_pass && (bus.in_set_flags || mdl_cmp))
                m_flags <= (bus.in_op inside {ADD, SUB, CMP}) ? mdl_res[W+3:W]
                                                              : {mdl_res[W+3:W+2], m_flags[1:0]};
        end else if (bus.out_ready) begin
            m_vld <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always begin
        @(posedge clk);
        #1;
        chk("in_ready",   {63'd0, bus.in_ready},  {63'd0, (!m_vld || bus.out_ready)});
        chk("out_valid",  {63'd0, bus.out_valid}, {63'd0, m_vld});
        chk("out_we",     {63'd0, bus.out_we},    {63'd0, m_we});
        chk("out_rd",     {60'd0, bus.out_rd},    {60'd0, m_rd});
        chk("out_data",   {32'd0, bus.out_data},  {32'd0, m_data});
        chk("flags",      {60'd0, flags},         {60'd0, m_flags});
        chk("retire_cnt", {56'd0, retire_cnt},    {56'd0, m_cnt});
        chk("op_err",     {63'd0, op_err},        {63'd0, m_err});
        chk("alu_a",      {32'd0, alu_a},         {32'd0, bus.in_op2});
        chk("alu_b",      {32'd0, alu_b},         {32'd0, bus.in_rn});
        chk("alu_sel",    {57'd0, alu_sel},       {57'd0, bus.in_op});
    end

    task automatic drive(input logic [6:0] op, input logic [3:0] cond, input logic s,
                         input logic [3:0] rd, input logic [W-1:0] rn, input logic [W-1:0] op2);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_cond = cond; bus.in_set_flags = s;
        bus.in_rd = rd; bus.in_rn = rn; bus.in_op2 = op2;
    endtask

    task automatic issue(input logic [6:0] op, input logic [3:0] cond, input logic s,
                         input logic [3:0] rd, input logic [W-1:0] rn, input logic [W-1:0] op2);
        @(negedge clk);
        drive(op, cond, s, rd, rn, op2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_cond = '0; bus.in_set_flags = 1'b0;
        bus.in_rd = '0; bus.in_rn = '0; bus.in_op2 = '0; bus.out_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst flags",     {60'd0, flags},         64'd0);
        chk("rst retire",    {56'd0, retire_cnt},    64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 chk("in_ready after reset", {63'd0, bus.in_ready}, 64'd1);

        issue(ADD, 4'b1110, 1'b1, 4'd1, 32'd5, 32'd7);
        chk("add out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("add out_we",    {63'd0, bus.out_we},    64'd1);
        chk("add data",      {32'd0, bus.out_data},  64'd12);
        chk("add flags",     {60'd0, flags},         64'd0);
        chk("add retire",    {56'd0, retire_cnt},    64'd1);

        issue(CMP, 4'b1110, 1'b0, 4'd2, 32'd3, 32'd3);
        chk("cmp out_we", {63'd0, bus.out_we}, 64'd0);
        chk("cmp flags",  {60'd0, flags},      64'b1010);
        issue(SUB, 4'b0000, 1'b0, 4'd3, 32'd9, 32'd4);
        chk("sub eq we",   {63'd0, bus.out_we},   64'd1);
        chk("sub eq data", {32'd0, bus.out_data}, 64'd5);
        chk("sub retire",  {56'd0, retire_cnt},   64'd3);

        issue(SUB, 4'b1110, 1'b1, 4'd4, 32'h8000_0000, 32'd1);
        chk("sub cv flags", {60'd0, flags}, 64'b0011);
        issue(AND, 4'b1110, 1'b1, 4'd5, 32'h0000_000F, 32'h0000_00F0);
        chk("and data",  {32'd0, bus.out_data}, 64'd0);
        chk("and flags", {60'd0, flags},        64'b1011);

        issue(ADD, 4'b0001, 1'b1, 4'd6, 32'd1, 32'd1);
        chk("ne out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("ne out_we",    {63'd0, bus.out_we},    64'd0);
        chk("ne flags",     {60'd0, flags},         64'b1011);
        chk("ne retire",    {56'd0, retire_cnt},    64'd5);
        issue(ADD, 4'b1111, 1'b1, 4'd7, 32'd1, 32'd2);
        chk("nv out_we",  {63'd0, bus.out_we},   64'd0);
        chk("nv retire",  {56'd0, retire_cnt},   64'd5);

        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(MOV, 4'b1110, 1'b1, 4'd8, 32'd0, 32'h55);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("stall in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("stall data",     {32'd0, bus.out_data}, 64'd3);
            chk("stall rd",       {60'd0, bus.out_rd},   64'd7);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 chk("resume data 1", {32'd0, bus.out_data}, 64'h55);
        issue(MOV, 4'b1110, 1'b0, 4'd9, 32'd0, 32'h66);
        chk("resume data 2", {32'd0, bus.out_data}, 64'h66);
        chk("resume rd 2",   {60'd0, bus.out_rd},   64'd9);

        issue(7'b0000011, 4'b1110, 1'b1, 4'd10, 32'd1, 32'd1);
        chk("badop we",  {63'd0, bus.out_we}, 64'd0);
        chk("badop err", {63'd0, op_err},     64'd1);
        issue(MOV, 4'b1110, 1'b0, 4'd1, 32'd0, 32'd1);
        chk("err sticky", {63'd0, op_err}, 64'd1);

        n = (1 << CNT_W) - int'(m_cnt);
        for (int i = 0; i < n - 1; i++)
            issue(MOV, 4'b1110, 1'b0, 4'd2, 32'd0, i);
        chk("cnt max", {56'd0, retire_cnt}, 64'hFF);
        issue(MOV, 4'b1110, 1'b0, 4'd2, 32'd0, 32'd0);
        chk("cnt wrap", {56'd0, retire_cnt}, 64'd0);

        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(ADD, 4'b1110, 1'b1, 4'd3, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid rst valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mid rst data",  {32'd0, bus.out_data},  64'd0);
        chk("mid rst err",   {63'd0, op_err},        64'd0);
        chk("mid rst flags", {60'd0, flags},         64'd0);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        reset_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            logic [6:0]   op;
            logic [W-1:0] a, b;
            @(negedge clk);
            op = (($urandom_range(0, 15) == 0) ? 7'($urandom) : (7'd1 << $urandom_range(0, 6)));
            case ($urandom_range(0, 3))
                0:       begin a = $urandom_range(0, 3); b = $urandom_range(0, 3); end
                1:       begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            drive(op, 4'($urandom), 1'($urandom), 4'($urandom), a, b);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Issue/retire controller that sits on the driving side of the combinational ALU. It accepts decoded data-processing operations over a valid/ready handshake and evaluates the condition field against the architectural NZCV flag register. It drives the ALU operands and one-hot select, then registers the result and flags. It presents a register-file write-back over a second valid/ready handshake.

## Interface
- W, 32, datapath width (ALU operand and result width)
- CNT_W, 16, width of the retired-operation counter

- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  controller can accept this cycle
- in_op  in  7  one-hot op: ADD=1000000, SUB=0100000, CMP=0010000, AND=0001000, ORR=0000100, EOR=0000010, MOV=0000001
- in_cond  in  4  ARM-style condition code
- in_set_flags  in  1  S bit (flag update request)
- in_rd  in  4  destination register index
- in_rn  in  W  first operand (Rn)
- in_op2  in  W  second operand
- alu_a  out  W  to ALU a; driven with in_op2
- alu_b  out  W  to ALU b; driven with in_rn
- alu_sel  out  7  to ALU select
- alu_data  in  W  ALU result
- alu_flag  in  4  ALU flags {Z,N,C,V} = bits [3:0]
- out_valid  out  1  write-back entry present
- out_ready  in  1  write-back consumer accepts
- out_we  out  1  entry writes the register file
- out_rd  out  4  destination index
- out_data  out  W  result
- flags  out  4  architectural NZCV register {Z,N,C,V}
- retire_cnt  out  CNT_W  count of condition-passed operations
- op_err  out  1  sticky: a non-one-hot in_op was accepted

## Operation
- Accept = in_valid && in_ready, with in_ready = !out_valid || out_ready. This gives a single output register with full throughput.
- The ALU computes b − a for SUB/CMP and passes a for MOV. The controller therefore drives alu_b=in_rn, alu_a=in_op2, and alu_sel=in_op combinationally from the input bus every cycle.
- The condition is evaluated against the current `flags` register:
  - 0000 EQ Z; 0001 NE !Z
  - 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 never
- On accept, the output register loads out_rd=in_rd and out_data=alu_data, with out_valid=1 in every case, so retirement order is preserved.
- out_we = pass && op is a valid one-hot && op != CMP.
- Flag update happens on accept only when pass && (in_set_flags || op==CMP) && op is valid:
  - ADD/SUB/CMP write all four flags from alu_flag.
  - AND/ORR/EOR/MOV write Z,N from alu_flag and keep C,V unchanged.
- Non-one-hot in_op (including all-zero): the operation is treated as a failed condition. out_we=0, no flag update, no count, and op_err is set. op_err clears only on reset.
- retire_cnt increments on each accepted op with pass && valid op, and wraps modulo 2^CNT_W.
- Without accept, when out_valid && out_ready, out_valid drops to 0. out_data, out_rd and out_we hold their values.

## Timing
- Reset (async, immediate): out_valid=0, out_we=0, out_rd=0, out_data=0, flags=0000, retire_cnt=0, op_err=0. After reset deassertion, in_ready=1.
- Latency: write-back appears 1 cycle after accept. Throughput is 1 op/cycle while out_ready=1.
- Flags written by op N are visible to the condition evaluation of op N+1 accepted on the next cycle, with no bubble.
- Stall: with out_valid=1 and out_ready=0, in_ready=0 and all out_* stay stable. Flags and counter do not change.
- Simultaneous out handshake and accept: the old entry retires and the new one loads in the same edge, so out_valid stays 1.
- Reset asserted mid-stall discards the pending entry without a write-back.
- The alu_* outputs are purely combinational from the in_* ports and carry no register.

## Test plan
- Reset, then ADD rn=5, op2=7, S=1, AL -> next cycle out_valid=1, out_we=1, out_data=12, flags=0000, retire_cnt=1.
- CMP rn=3, op2=3, AL, then back-to-back SUB (EQ, rn=9, op2=4) -> first op: out_we=0, flags Z=1 C=1; second op passes with out_data=5 and no bubble.
- Set C=1, V=1 via SUB rn=0x80000000, op2=1, S=1, then AND S=1 producing 0 -> Z=1, N=0, C=1, V=1 retained.
- ADD with cond NE while Z=1 -> out_valid=1, out_we=0, flags unchanged, retire_cnt unchanged; repeat with cond=1111 -> same result.
- Hold out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, out_* stable, flags unchanged; release -> one op per cycle resumes in order.
- Accept in_op=0000011 -> out_we=0, op_err=1 sticky; run 2^CNT_W passing ops -> retire_cnt wraps to 0; assert reset_n=0 mid-stall -> all outputs return to reset values immediately.
